// File: rtl/ddram_pkg.sv
// ddram_pkg
//   Shared definitions for the HPS download packer feeding the DDRAM
//   arbiter's ch1 port.
//   - DDRAM_WORD_W / DDRAM_LANES : packed word width and number of byte lanes
//   - DDRAM_BASE_DEFAULT         : default byte offset applied to ch1_addr
//   - dl_state_t                 : packer FSM states
package ddram_pkg;

  localparam int DDRAM_WORD_W = 64;
  localparam int DDRAM_LANES  = 8;

  localparam logic [27:0] DDRAM_BASE_DEFAULT = 28'h0000000;

  // ST_FILL  : collecting bytes, HPS may strobe
  // ST_ISSUE : single cycle with ch1_req high
  // ST_WAIT  : request outstanding, waiting for ch1_ready
  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } dl_state_t;

endpackage

// File: rtl/ddram_lane_merge.sv
// ddram_lane_merge
//   Combinational byte-lane insert: writes one byte into the selected lane of
//   a 64-bit little-endian word and marks that lane valid.
//   Ports:
//     word_in  : current word (lane i = bits [8i+7:8i])
//     mask_in  : current valid-lane mask
//     lane     : lane to overwrite
//     data     : byte to place in that lane
//     word_out : word with the lane replaced
//     mask_out : mask with the lane bit set
module ddram_lane_merge
  import ddram_pkg::*;
(
  input  logic [DDRAM_WORD_W-1:0] word_in,
  input  logic [DDRAM_LANES-1:0]  mask_in,
  input  logic [2:0]              lane,
  input  logic [7:0]              data,
  output logic [DDRAM_WORD_W-1:0] word_out,
  output logic [DDRAM_LANES-1:0]  mask_out
);

  for (genvar gi = 0; gi < DDRAM_LANES; gi++) begin : g_lane
    logic hit;
    assign hit                 = (lane == 3'(gi));
    assign word_out[8*gi +: 8] = hit ? data : word_in[8*gi +: 8];
    assign mask_out[gi]        = mask_in[gi] | hit;
  end

endmodule

// File: rtl/ddram_dl_packer.sv
// ddram_dl_packer
//   Packs the HPS byte-wide ROM download stream into 64-bit little-endian
//   words and writes each word through the DDRAM arbiter's ch1 port. The HPS
//   is throttled with ioctl_wait while a word is in flight; a partially filled
//   word is flushed (unused lanes = FILL) on a word-address jump or at the end
//   of the download.
//   Ports:
//     DDRAM_CLK      : sole clock
//     reset          : synchronous, active-high
//     ioctl_download : high for the whole download
//     ioctl_wr       : one-cycle byte strobe
//     ioctl_addr     : byte address
//     ioctl_dout     : byte data
//     ioctl_wait     : HPS must not strobe while high
//     ch1_addr       : byte address of the word being written (bits[2:0]=0)
//     ch1_din        : packed word
//     ch1_req        : one-cycle request pulse
//     ch1_rnw        : always 0, write only
//     ch1_ready      : write-accepted pulse from the arbiter
//     dl_done        : one-cycle pulse once all data is committed
//     words_written  : ch1 writes in the current download (wraps)
module ddram_dl_packer
  import ddram_pkg::*;
#(
  parameter int          ADDR_W = 25,
  parameter logic [27:0] BASE   = DDRAM_BASE_DEFAULT,
  parameter logic [7:0]  FILL   = 8'h00
) (
  input  logic              DDRAM_CLK,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic [27:0]       ch1_addr,
  output logic [63:0]       ch1_din,
  output logic              ch1_req,
  output logic              ch1_rnw,
  input  logic              ch1_ready,
  output logic              dl_done,
  output logic [ADDR_W-3:0] words_written
);

  localparam int WA_W = ADDR_W - 3;
  localparam logic [DDRAM_WORD_W-1:0] FILL_WORD = {DDRAM_LANES{FILL}};
  localparam logic [ADDR_W-3:0] CNT_ONE = (ADDR_W-2)'(1);

  dl_state_t               state_reg;
  logic [DDRAM_WORD_W-1:0] word_reg;
  logic [DDRAM_LANES-1:0]  vmask_reg;
  logic [WA_W-1:0]         wa_reg;
  logic [7:0]              hold_byte_reg;
  logic [ADDR_W-1:0]       hold_addr_reg;
  logic                    hold_flag_reg;
  logic                    end_pending_reg;
  logic                    dl_q_reg;
  logic                    dl_done_reg;
  logic [ADDR_W-3:0]       count_reg;

  logic [2:0]              in_lane;
  logic [WA_W-1:0]         in_wa;
  logic [WA_W-1:0]         hold_wa;
  logic                    dl_rise;
  logic                    dl_fall;
  logic                    byte_stb;
  logic                    same_word;
  logic                    ready_hit;
  logic                    end_now;

  logic [DDRAM_WORD_W-1:0] mrg_word_in;
  logic [DDRAM_LANES-1:0]  mrg_mask_in;
  logic [2:0]              mrg_lane;
  logic [7:0]              mrg_data;
  logic [DDRAM_WORD_W-1:0] mrg_word_out;
  logic [DDRAM_LANES-1:0]  mrg_mask_out;

  assign in_lane   = ioctl_addr[2:0];
  assign in_wa     = ioctl_addr[ADDR_W-1:3];
  assign hold_wa   = hold_addr_reg[ADDR_W-1:3];
  assign dl_rise   = ioctl_download & ~dl_q_reg;
  assign dl_fall   = dl_q_reg & ~ioctl_download;
  assign byte_stb  = ioctl_wr & ioctl_download & (state_reg == ST_FILL);
  assign same_word = (vmask_reg == '0) || (in_wa == wa_reg);
  assign ready_hit = ch1_ready & (state_reg == ST_WAIT);
  // An end-of-download seen in the same cycle as the ready still counts.
  assign end_now   = end_pending_reg | dl_fall;

  // One merge unit serves both paths: incoming strobes land in the live
  // buffer, while in WAIT the held byte seeds a fresh, all-FILL buffer.
  always_comb begin
    if (state_reg == ST_WAIT) begin
      mrg_word_in = FILL_WORD;
      mrg_mask_in = '0;
      mrg_lane    = hold_addr_reg[2:0];
      mrg_data    = hold_byte_reg;
    end else begin
      mrg_word_in = word_reg;
      mrg_mask_in = vmask_reg;
      mrg_lane    = in_lane;
      mrg_data    = ioctl_dout;
    end
  end

  ddram_lane_merge u_merge (
    .word_in  (mrg_word_in),
    .mask_in  (mrg_mask_in),
    .lane     (mrg_lane),
    .data     (mrg_data),
    .word_out (mrg_word_out),
    .mask_out (mrg_mask_out)
  );

  always_ff @(posedge DDRAM_CLK) begin
    if (reset) begin
      state_reg       <= ST_FILL;
      word_reg        <= FILL_WORD;
      vmask_reg       <= '0;
      wa_reg          <= '0;
      hold_byte_reg   <= '0;
      hold_addr_reg   <= '0;
      hold_flag_reg   <= 1'b0;
      end_pending_reg <= 1'b0;
      dl_q_reg        <= 1'b0;
      dl_done_reg     <= 1'b0;
      count_reg       <= '0;
    end else begin
      dl_q_reg    <= ioctl_download;
      dl_done_reg <= 1'b0;

      if (dl_rise) begin
        count_reg <= '0;
      end else if (ready_hit) begin
        count_reg <= count_reg + CNT_ONE;
      end

      case (state_reg)
        ST_FILL: begin
          if (dl_fall) begin
            if (vmask_reg != '0) begin
              state_reg       <= ST_ISSUE;
              end_pending_reg <= 1'b1;
            end else begin
              dl_done_reg <= 1'b1;
            end
          end else if (byte_stb) begin
            if (same_word) begin
              word_reg  <= mrg_word_out;
              vmask_reg <= mrg_mask_out;
              wa_reg    <= in_wa;
              if (in_lane == 3'd7) begin
                state_reg <= ST_ISSUE;
              end
            end else begin
              // Word jump: park the new byte and flush the old word padded.
              hold_byte_reg <= ioctl_dout;
              hold_addr_reg <= ioctl_addr;
              hold_flag_reg <= 1'b1;
              state_reg     <= ST_ISSUE;
            end
          end
        end

        ST_ISSUE: begin
          if (dl_fall) begin
            end_pending_reg <= 1'b1;
          end
          state_reg <= ST_WAIT;
        end

        ST_WAIT: begin
          if (ready_hit) begin
            if (hold_flag_reg) begin
              word_reg        <= mrg_word_out;
              vmask_reg       <= mrg_mask_out;
              wa_reg          <= hold_wa;
              hold_flag_reg   <= 1'b0;
              end_pending_reg <= end_now;
              // A held byte must still be flushed if the download already
              // ended; a held lane-7 byte completes its word on its own.
              if (end_now || (hold_addr_reg[2:0] == 3'd7)) begin
                state_reg <= ST_ISSUE;
              end else begin
                state_reg <= ST_FILL;
              end
            end else begin
              word_reg        <= FILL_WORD;
              vmask_reg       <= '0;
              end_pending_reg <= 1'b0;
              state_reg       <= ST_FILL;
              if (end_now) begin
                dl_done_reg <= 1'b1;
              end
            end
          end else if (dl_fall) begin
            end_pending_reg <= 1'b1;
          end
        end

        default: state_reg <= ST_FILL;
      endcase
    end
  end

  assign ioctl_wait    = (state_reg != ST_FILL);
  assign ch1_req       = (state_reg == ST_ISSUE);
  assign ch1_rnw       = 1'b0;
  assign ch1_addr      = BASE + 28'({wa_reg, 3'b000});
  assign ch1_din       = word_reg;
  assign dl_done       = dl_done_reg;
  assign words_written = count_reg;

endmodule

// File: tb/tb_ddram_dl_packer.sv
// tb_ddram_dl_packer
//   Directed bench for ddram_dl_packer. A byte-level reference packer turns
//   each driven byte stream into the list of words that must appear on ch1;
//   a per-cycle monitor compares every request against that list and tracks
//   the expected words_written count. Literal expectations pin the model.
module tb_ddram_dl_packer;

  localparam int          ADDR_W = 25;
  localparam logic [27:0] BASE   = 28'h0000000;
  localparam logic [7:0]  FILL   = 8'h00;

  logic              clk = 1'b0;
  logic              reset;
  logic              ioctl_download;
  logic              ioctl_wr;
  logic [ADDR_W-1:0] ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic              ioctl_wait;
  logic [27:0]       ch1_addr;
  logic [63:0]       ch1_din;
  logic              ch1_req;
  logic              ch1_rnw;
  logic              ch1_ready;
  logic              dl_done;
  logic [ADDR_W-3:0] words_written;

  always #5 clk = ~clk;

  ddram_dl_packer #(.ADDR_W(ADDR_W), .BASE(BASE), .FILL(FILL)) dut (
    .DDRAM_CLK      (clk),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .ch1_addr       (ch1_addr),
    .ch1_din        (ch1_din),
    .ch1_req        (ch1_req),
    .ch1_rnw        (ch1_rnw),
    .ch1_ready      (ch1_ready),
    .dl_done        (dl_done),
    .words_written  (words_written)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference packer ----------------
  logic [27:0] exp_addr_q[$];
  logic [63:0] exp_din_q[$];
  logic [27:0] hist_addr[$];
  logic [63:0] hist_din[$];
  logic [7:0]  m_buf[8];
  logic [7:0]  m_mask;
  int unsigned m_wa;

  function automatic void m_clear();
    for (int i = 0; i < 8; i++) m_buf[i] = FILL;
    m_mask = 8'h00;
  endfunction

  function automatic void m_push();
    logic [63:0] w;
    logic [27:0] a;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = m_buf[i];
    a = BASE + 28'(m_wa * 8);
    exp_addr_q.push_back(a);
    exp_din_q.push_back(w);
    hist_addr.push_back(a);
    hist_din.push_back(w);
    m_clear();
  endfunction

  function automatic void m_byte(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    int unsigned wa;
    logic [2:0] lane;
    wa   = int'(a[ADDR_W-1:3]);
    lane = a[2:0];
    if (m_mask != 8'h00 && wa != m_wa) m_push();
    m_buf[lane]  = d;
    m_mask[lane] = 1'b1;
    m_wa         = wa;
    if (lane == 3'd7) m_push();
  endfunction

  // ---------------- arbiter model ----------------
  int arb_delay = 1;
  initial begin
    ch1_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (ch1_req === 1'b1) begin
        repeat (arb_delay) @(posedge clk);
        #1 ch1_ready = 1'b1;
        @(posedge clk);
        #1 ch1_ready = 1'b0;
      end
    end
  end

  // ---------------- per-cycle monitor ----------------
  int          cyc = 0;
  bit          chk_en = 1'b0;
  bit          outstanding = 1'b0;
  bit          ready_now;
  bit          dl_prev = 1'b0;
  int          ww_m = 0;
  int          req_cnt = 0, wait_cnt = 0, viol_cnt = 0, done_cnt = 0;
  int          done_cyc = -1, ready_cyc = -1, drop_cyc = -1;
  logic [27:0] lat_addr;
  logic [63:0] lat_din;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      ready_now = 1'b0;
      check("words_written", 64'(words_written), 64'(ww_m));
      check("ch1_rnw", 64'(ch1_rnw), 64'd0);
      if (ioctl_wait === 1'b1) wait_cnt++;
      if (ioctl_wr === 1'b1 && ioctl_wait === 1'b1) viol_cnt++;
      if (dl_done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (ch1_req === 1'b1) begin
        req_cnt++;
        check("req_overlap", 64'(outstanding), 64'd0);
        check("req_expected", 64'(exp_addr_q.size() != 0), 64'd1);
        if (exp_addr_q.size() != 0) begin
          check("ch1_addr", 64'(ch1_addr), 64'(exp_addr_q[0]));
          check("ch1_din", ch1_din, exp_din_q[0]);
          void'(exp_addr_q.pop_front());
          void'(exp_din_q.pop_front());
        end
        check("wait_on_issue", 64'(ioctl_wait), 64'd1);
        outstanding = 1'b1;
        lat_addr    = ch1_addr;
        lat_din     = ch1_din;
      end else if (outstanding) begin
        check("addr_stable", 64'(ch1_addr), 64'(lat_addr));
        check("din_stable", ch1_din, lat_din);
        check("wait_in_flight", 64'(ioctl_wait), 64'd1);
        if (ch1_ready === 1'b1) begin
          ready_now   = 1'b1;
          outstanding = 1'b0;
          ready_cyc   = cyc;
        end
      end
      if (reset === 1'b1) begin
        ww_m        = 0;
        outstanding = 1'b0;
        dl_prev     = 1'b0;
      end else begin
        if (ioctl_download === 1'b1 && !dl_prev) ww_m = 0;
        else if (ready_now) ww_m++;
        dl_prev = (ioctl_download === 1'b1);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_dl();
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    drop_cyc = cyc;
    if (m_mask != 8'h00) m_push();
  endtask

  task automatic send_byte(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    int guard = 0;
    while (ioctl_wait !== 1'b0 && guard < 200) begin
      tick();
      guard++;
    end
    if (guard >= 200) check("send_wait_timeout", 64'(ioctl_wait), 64'd0);
    m_byte(a, d);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((exp_addr_q.size() != 0 || outstanding || ioctl_wait !== 1'b0) && guard < 400) begin
      tick();
      guard++;
    end
    check("idle_queue_empty", 64'(exp_addr_q.size()), 64'd0);
    check("idle_wait_low", 64'(ioctl_wait), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  int req0, done0;

  initial begin
    reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = 8'h00;
    m_clear();
    m_wa = 0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wait", 64'(ioctl_wait), 64'd0);
    check("rst_req", 64'(ch1_req), 64'd0);
    check("rst_rnw", 64'(ch1_rnw), 64'd0);
    check("rst_addr", 64'(ch1_addr), 64'(BASE));
    check("rst_din", ch1_din, {8{FILL}});
    check("rst_done", 64'(dl_done), 64'd0);
    check("rst_ww", 64'(words_written), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;

    // T1: sixteen sequential bytes, ready one cycle after req
    start_dl();
    wait_cnt = 0;
    req0 = req_cnt;
    for (int i = 0; i < 16; i++) send_byte(ADDR_W'(i), 8'(i));
    wait_idle();
    $display("T1 sequential: reqs=%0d wait_cycles=%0d words_written=%0d", req_cnt - req0, wait_cnt, words_written);
    check("t1_w0_addr", 64'(hist_addr[0]), 64'h0);
    check("t1_w0_din", hist_din[0], 64'h0706050403020100);
    check("t1_w1_addr", 64'(hist_addr[1]), 64'h8);
    check("t1_w1_din", hist_din[1], 64'h0F0E0D0C0B0A0908);
    check("t1_reqs", 64'(req_cnt - req0), 64'd2);
    check("t1_ww", 64'(words_written), 64'd2);
    check("t1_wait_cycles", 64'(wait_cnt), 64'd4);
    done0 = done_cnt;
    end_dl();
    repeat (3) tick();
    check("t1_done_count", 64'(done_cnt - done0), 64'd1);
    check("t1_done_timing", 64'(done_cyc), 64'(drop_cyc + 1));

    // T2: eleven bytes then end of download, padded flush
    start_dl();
    check("t2_ww_cleared", 64'(words_written), 64'd0);
    for (int i = 0; i < 11; i++) send_byte(ADDR_W'(i), 8'hA0 + 8'(i));
    done0 = done_cnt;
    end_dl();
    wait_idle();
    repeat (3) tick();
    $display("T2 partial flush: addr=%0h din=%h done_cyc=%0d ready_cyc=%0d", hist_addr[3], hist_din[3], done_cyc, ready_cyc);
    check("t2_flush_addr", 64'(hist_addr[3]), 64'h8);
    check("t2_flush_din", hist_din[3], 64'h0000000000AAA9A8);
    check("t2_done_count", 64'(done_cnt - done0), 64'd1);
    check("t2_done_timing", 64'(done_cyc), 64'(ready_cyc + 1));
    check("t2_ww", 64'(words_written), 64'd2);

    // T3: word jump holds the new byte while the old word flushes
    start_dl();
    check("t3_ww_cleared", 64'(words_written), 64'd0);
    send_byte(ADDR_W'(32'h13), 8'h55);
    send_byte(ADDR_W'(32'h20), 8'h66);
    wait_idle();
    $display("T3 word jump: flush addr=%0h din=%h, buffer addr=%0h din=%h", hist_addr[4], hist_din[4], ch1_addr, ch1_din);
    check("t3_flush_addr", 64'(hist_addr[4]), 64'h10);
    check("t3_flush_din", hist_din[4], 64'h0000000055000000);
    check("t3_buf_addr", 64'(ch1_addr), 64'h20);
    check("t3_buf_din", ch1_din, 64'h0000000000000066);
    check("t3_ww", 64'(words_written), 64'd1);
    end_dl();
    wait_idle();
    repeat (3) tick();
    check("t3_tail_din", hist_din[5], 64'h0000000000000066);

    // T4: slow arbiter, strobe injected while throttled
    arb_delay = 20;
    start_dl();
    wait_cnt = 0;
    viol_cnt = 0;
    req0 = req_cnt;
    for (int i = 0; i < 8; i++) send_byte(ADDR_W'(32'h40 + i), 8'h10 + 8'(i));
    tick();
    ioctl_wr = 1'b1; ioctl_addr = ADDR_W'(32'h48); ioctl_dout = 8'hEE;
    tick();
    ioctl_wr = 1'b0;
    wait_idle();
    $display("T4 slow ready: reqs=%0d wait_cycles=%0d violations=%0d", req_cnt - req0, wait_cnt, viol_cnt);
    check("t4_reqs", 64'(req_cnt - req0), 64'd1);
    check("t4_wait_cycles", 64'(wait_cnt), 64'd21);
    check("t4_violations", 64'(viol_cnt), 64'd1);
    check("t4_din", hist_din[6], 64'h1716151413121110);
    done0 = done_cnt;
    end_dl();
    repeat (3) tick();
    check("t4_done_count", 64'(done_cnt - done0), 64'd1);
    check("t4_no_extra_req", 64'(req_cnt - req0), 64'd1);

    // T5: reset while waiting for ready; the late ready must be ignored
    start_dl();
    for (int i = 0; i < 8; i++) send_byte(ADDR_W'(i), 8'h30 + 8'(i));
    repeat (3) tick();
    check("t5_in_wait", 64'(ioctl_wait), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_clear();
    @(negedge clk);
    check("t5_rst_wait", 64'(ioctl_wait), 64'd0);
    check("t5_rst_req", 64'(ch1_req), 64'd0);
    check("t5_rst_ww", 64'(words_written), 64'd0);
    req0 = req_cnt;
    repeat (25) tick();
    $display("T5 reset in wait: wait=%0d ww=%0d reqs_after=%0d", ioctl_wait, words_written, req_cnt - req0);
    check("t5_late_ww", 64'(words_written), 64'd0);
    check("t5_late_wait", 64'(ioctl_wait), 64'd0);
    check("t5_late_reqs", 64'(req_cnt - req0), 64'd0);
    arb_delay = 1;
    end_dl();
    repeat (3) tick();

    // T6: empty download
    req0 = req_cnt;
    done0 = done_cnt;
    start_dl();
    repeat (2) tick();
    end_dl();
    repeat (4) tick();
    $display("T6 empty download: done_cyc=%0d drop_cyc=%0d reqs=%0d", done_cyc, drop_cyc, req_cnt - req0);
    check("t6_done_count", 64'(done_cnt - done0), 64'd1);
    check("t6_done_timing", 64'(done_cyc), 64'(drop_cyc + 1));
    check("t6_no_req", 64'(req_cnt - req0), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
